// File: rtl/avalon_pkg.sv
// Shared Avalon-MM types: the agent response code and the copy-host FSM state encoding.
package avalon_pkg;

    typedef enum logic [1:0] {
        OKAY     = 2'b00,
        RESERVED = 2'b01,
        SLVERR   = 2'b10,
        DECERR   = 2'b11
    } avalon_resp_t;

    typedef enum logic [2:0] {
        CS_IDLE   = 3'd0,
        CS_RD_REQ = 3'd1,
        CS_RD_RSP = 3'd2,
        CS_WR_REQ = 3'd3,
        CS_WR_RSP = 3'd4,
        CS_DONE   = 3'd5
    } copy_state_t;

endpackage

// File: rtl/avalon_if.sv
// Avalon-MM bus between one host and the single-port byte RAM agent.
// Handshake: there is no waitrequest. A read or write strobe is accepted in
// the same cycle it is high. readdata (for reads) and response (for any
// access) are valid exactly one cycle after the strobe. Outside that cycle
// response carries no meaning for the host.
interface avalon_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) ();
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic [1:0]        response;

    modport host (
        output address, read, write, writedata,
        input  readdata, response
    );

    modport agent (
        input  address, read, write, writedata,
        output readdata, response
    );
endinterface

// File: rtl/avalon_copy_host.sv
// Avalon-MM host that copies len bytes from src_addr to dst_addr inside one
// byte RAM agent: one read and one write per byte, strictly ascending, with
// the agent response checked after every access. Any non-OKAY response aborts
// the copy and records the failing address.
module avalon_copy_host
    import avalon_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] err_addr,
    output logic [2:0]        dbg_state,
    avalon_if.host            av
);

    localparam logic [2:0] ST_IDLE   = CS_IDLE;
    localparam logic [2:0] ST_RD_REQ = CS_RD_REQ;
    localparam logic [2:0] ST_RD_RSP = CS_RD_RSP;
    localparam logic [2:0] ST_WR_REQ = CS_WR_REQ;
    localparam logic [2:0] ST_WR_RSP = CS_WR_RSP;
    localparam logic [2:0] ST_DONE   = CS_DONE;

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);

    logic [2:0]        state;
    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic [LEN_W-1:0]  remaining;
    logic [DATA_W-1:0] data_q;
    logic              error_q;
    logic [ADDR_W-1:0] err_addr_q;
    logic              resp_bad;

    // Only OKAY counts as success; RESERVED, SLVERR and DECERR all abort.
    assign resp_bad = (avalon_resp_t'(av.response) != OKAY);

    // Control FSM plus pointer/counter datapath; pointers wrap modulo 2**ADDR_W.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            src_ptr    <= '0;
            dst_ptr    <= '0;
            remaining  <= '0;
            data_q     <= '0;
            error_q    <= 1'b0;
            err_addr_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        src_ptr   <= src_addr;
                        dst_ptr   <= dst_addr;
                        remaining <= len;
                        error_q   <= 1'b0;
                        state     <= (len == '0) ? ST_DONE : ST_RD_REQ;
                    end
                end
                ST_RD_REQ: state <= ST_RD_RSP;
                ST_RD_RSP: begin
                    data_q <= av.readdata;
                    if (resp_bad) begin
                        error_q    <= 1'b1;
                        err_addr_q <= src_ptr;
                        state      <= ST_DONE;
                    end else begin
                        state <= ST_WR_REQ;
                    end
                end
                ST_WR_REQ: state <= ST_WR_RSP;
                ST_WR_RSP: begin
                    if (resp_bad) begin
                        error_q    <= 1'b1;
                        err_addr_q <= dst_ptr;
                        state      <= ST_DONE;
                    end else begin
                        src_ptr   <= src_ptr + ADDR_ONE;
                        dst_ptr   <= dst_ptr + ADDR_ONE;
                        remaining <= remaining - LEN_ONE;
                        // remaining still holds the pre-decrement count here
                        state     <= (remaining == LEN_ONE) ? ST_DONE : ST_RD_REQ;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Bus strobes and address/data are pure decodes of the state register,
    // so read and write can never be high together and reset zeroes them.
    always_comb begin
        av.read      = (state == ST_RD_REQ);
        av.write     = (state == ST_WR_REQ);
        av.address   = '0;
        av.writedata = '0;
        if (state == ST_RD_REQ) begin
            av.address = src_ptr;
        end else if (state == ST_WR_REQ) begin
            av.address   = dst_ptr;
            av.writedata = data_q;
        end
    end

    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign error     = error_q;
    assign err_addr  = err_addr_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_avalon_copy_host.sv
// Bench for avalon_copy_host: a behavioural byte-RAM agent on the bus,
// directed copies, and a negedge monitor that pops expected reads, writes
// and completions from queues filled by the stimulus thread.
module tb_avalon_copy_host;
    import avalon_pkg::*;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 11;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- DUT ----------------
    logic              start = 1'b0;
    logic [ADDR_W-1:0] src_addr = '0;
    logic [ADDR_W-1:0] dst_addr = '0;
    logic [LEN_W-1:0]  len = '0;
    logic              busy, done, error;
    logic [ADDR_W-1:0] err_addr;
    logic [2:0]        dbg_state;

    avalon_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    avalon_copy_host #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .busy(busy), .done(done), .error(error), .err_addr(err_addr),
        .dbg_state(dbg_state), .av(bus.host)
    );

    // ---------------- RAM agent model ----------------
    logic [7:0]        mem [0:1023];
    logic [7:0]        shadow [0:1023];
    logic              bd_we = 1'b0;
    logic [ADDR_W-1:0] bd_addr = '0;
    logic [7:0]        bd_data = '0;
    logic              fault_en = 1'b0;
    logic [ADDR_W-1:0] fault_addr = '0;

    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        if (bus.read) begin
            bus.readdata <= mem[bus.address];
            bus.response <= OKAY;
        end else if (bus.write) begin
            if (fault_en && bus.address == fault_addr) begin
                bus.response <= SLVERR;
            end else begin
                mem[bus.address] <= bus.writedata;
                bus.response     <= OKAY;
            end
        end else begin
            bus.response <= SLVERR;
        end
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_err    = 0;
    int t0       = 0;

    logic [9:0]  exp_rd_q[$];
    logic [17:0] exp_wr_q[$];    // {addr, data}
    logic [26:0] exp_done_q[$];  // {error, err_addr, cycle}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        n_checks++;
        n_err++;
        $display("FAIL %s: got %0h, expected no such event (t=%0t)", name, act, $time);
    endtask

    // Monitor: every strobe and done pulse must match the head of its queue.
    always @(negedge clk) begin
        if (rst) begin
            check("rd_wr_exclusive", {31'b0, bus.read & bus.write}, 32'd0);
            if (bus.read) begin
                if (exp_rd_q.size() == 0) fail_now("unexpected_read", {22'b0, bus.address});
                else check("rd_addr", {22'b0, bus.address}, {22'b0, exp_rd_q.pop_front()});
            end
            if (bus.write) begin
                if (exp_wr_q.size() == 0) begin
                    fail_now("unexpected_write", {22'b0, bus.address});
                end else begin
                    logic [17:0] e;
                    e = exp_wr_q.pop_front();
                    check("wr_addr", {22'b0, bus.address}, {22'b0, e[17:8]});
                    check("wr_data", {24'b0, bus.writedata}, {24'b0, e[7:0]});
                end
            end
            if (done) begin
                if (exp_done_q.size() == 0) begin
                    fail_now("unexpected_done", cyc - t0 + 1);
                end else begin
                    logic [26:0] d;
                    d = exp_done_q.pop_front();
                    check("done_cycle", cyc - t0 + 1, {16'b0, d[15:0]});
                    check("done_error", {31'b0, error}, {31'b0, d[26]});
                    if (d[26]) check("done_err_addr", {22'b0, err_addr}, {22'b0, d[25:16]});
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic poke(input logic [ADDR_W-1:0] a, input logic [7:0] v);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = a; bd_data = v;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    // Returns in cycle 1 of the copy (just after the accepting edge).
    task automatic start_copy(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                              input logic [LEN_W-1:0] l);
        @(negedge clk);
        src_addr = s; dst_addr = d; len = l; start = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        start = 1'b0;
    endtask

    // Pushes the expected bus accesses of an ascending byte copy, using a
    // sequential shadow of the RAM so overlapping regions replicate bytes.
    task automatic expect_copy(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                               input int n_rd, input int n_wr);
        logic [ADDR_W-1:0] sa, da;
        for (int i = 0; i < 1024; i++) shadow[i] = mem[i];
        for (int i = 0; i < n_rd; i++) exp_rd_q.push_back(s + ADDR_W'(i));
        for (int i = 0; i < n_wr; i++) begin
            sa = s + ADDR_W'(i);
            da = d + ADDR_W'(i);
            exp_wr_q.push_back({da, shadow[sa]});
            shadow[da] = shadow[sa];
        end
    endtask

    task automatic expect_done(input logic e, input logic [ADDR_W-1:0] ea, input int c);
        exp_done_q.push_back({e, ea, 16'(c)});
    endtask

    task automatic wait_done();
        bool_loop: begin
            for (int k = 0; k < 300; k++) begin
                @(posedge clk);
                if (exp_done_q.size() == 0) disable bool_loop;
            end
            fail_now("done_timeout", exp_done_q.size());
            exp_done_q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
        check("reads_left", exp_rd_q.size(), 0);
        check("writes_left", exp_wr_q.size(), 0);
        exp_rd_q.delete();
        exp_wr_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_error", {31'b0, error}, 0);
        check("rst_state", {29'b0, dbg_state}, 0);
        check("rst_av_read", {31'b0, bus.read}, 0);
        check("rst_av_write", {31'b0, bus.write}, 0);
        @(negedge clk);
        rst = 1'b1;

        poke(10'h010, 8'hA0); poke(10'h011, 8'hA1);
        poke(10'h012, 8'hA2); poke(10'h013, 8'hA3);
        poke(10'h3FE, 8'hB0); poke(10'h3FF, 8'hB1);
        poke(10'h000, 8'hB2); poke(10'h001, 8'hB3);
        poke(10'h040, 8'h5A); poke(10'h041, 8'h11);
        poke(10'h042, 8'h22); poke(10'h043, 8'h33);

        // Basic copy with busy profile: high in cycles 1..17, low in 18.
        expect_copy(10'h010, 10'h100, 4, 4);
        expect_done(1'b0, 10'h000, 17);
        start_copy(10'h010, 10'h100, 11'd4);
        for (int k = 1; k <= 17; k++) begin
            check($sformatf("busy_c%0d", k), {31'b0, busy}, 1);
            @(posedge clk);
            #1;
        end
        check("busy_c18", {31'b0, busy}, 0);
        wait_done();
        check("basic_ram100", {24'b0, mem[10'h100]}, 32'hA0);
        check("basic_ram101", {24'b0, mem[10'h101]}, 32'hA1);
        check("basic_ram102", {24'b0, mem[10'h102]}, 32'hA2);
        check("basic_ram103", {24'b0, mem[10'h103]}, 32'hA3);
        check("basic_error", {31'b0, error}, 0);

        // Zero length: done in cycle 1, no bus activity.
        expect_done(1'b0, 10'h000, 1);
        start_copy(10'h013, 10'h100, 11'd0);
        wait_done();
        check("zero_ram100", {24'b0, mem[10'h100]}, 32'hA0);

        // Wrap-around source.
        expect_copy(10'h3FE, 10'h020, 4, 4);
        expect_done(1'b0, 10'h000, 17);
        start_copy(10'h3FE, 10'h020, 11'd4);
        wait_done();
        check("wrap_ram020", {24'b0, mem[10'h020]}, 32'hB0);
        check("wrap_ram021", {24'b0, mem[10'h021]}, 32'hB1);
        check("wrap_ram022", {24'b0, mem[10'h022]}, 32'hB2);
        check("wrap_ram023", {24'b0, mem[10'h023]}, 32'hB3);

        // Error abort on the second write; done in cycle 9.
        poke(10'h100, 8'h00); poke(10'h101, 8'h00);
        poke(10'h102, 8'h00); poke(10'h103, 8'h00);
        fault_en = 1'b1; fault_addr = 10'h101;
        expect_copy(10'h010, 10'h100, 2, 2);
        expect_done(1'b1, 10'h101, 9);
        start_copy(10'h010, 10'h100, 11'd4);
        wait_done();
        fault_en = 1'b0;
        check("abort_error", {31'b0, error}, 1);
        check("abort_err_addr", {22'b0, err_addr}, 32'h101);
        check("abort_ram100", {24'b0, mem[10'h100]}, 32'hA0);
        check("abort_ram101", {24'b0, mem[10'h101]}, 32'h00);
        check("abort_ram102", {24'b0, mem[10'h102]}, 32'h00);

        // Next accepted start clears the sticky error.
        expect_copy(10'h010, 10'h200, 1, 1);
        expect_done(1'b0, 10'h000, 5);
        start_copy(10'h010, 10'h200, 11'd1);
        check("error_cleared", {31'b0, error}, 0);
        wait_done();
        check("recover_ram200", {24'b0, mem[10'h200]}, 32'hA0);

        // Overlap dst = src + 1 replicates the first byte.
        expect_copy(10'h040, 10'h041, 3, 3);
        expect_done(1'b0, 10'h000, 13);
        start_copy(10'h040, 10'h041, 11'd3);
        wait_done();
        check("overlap_ram041", {24'b0, mem[10'h041]}, 32'h5A);
        check("overlap_ram042", {24'b0, mem[10'h042]}, 32'h5A);
        check("overlap_ram043", {24'b0, mem[10'h043]}, 32'h5A);

        // start pulsed in cycle 5 of a busy copy is ignored.
        expect_copy(10'h010, 10'h300, 4, 4);
        expect_done(1'b0, 10'h000, 17);
        start_copy(10'h010, 10'h300, 11'd4);
        repeat (4) @(posedge clk);
        @(negedge clk);
        src_addr = 10'h3FE; dst_addr = 10'h000; len = 11'd1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();
        check("busy_start_ram300", {24'b0, mem[10'h300]}, 32'hA0);
        check("busy_start_ram303", {24'b0, mem[10'h303]}, 32'hA3);
        check("busy_start_ram000", {24'b0, mem[10'h000]}, 32'hB2);

        // Reset in cycle 6: one byte written, outputs cleared, no done.
        expect_copy(10'h010, 10'h380, 2, 1);
        start_copy(10'h010, 10'h380, 11'd4);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_busy", {31'b0, busy}, 0);
        check("mid_rst_done", {31'b0, done}, 0);
        check("mid_rst_error", {31'b0, error}, 0);
        check("mid_rst_err_addr", {22'b0, err_addr}, 0);
        check("mid_rst_state", {29'b0, dbg_state}, 0);
        check("mid_rst_av_read", {31'b0, bus.read}, 0);
        check("mid_rst_av_write", {31'b0, bus.write}, 0);
        check("mid_rst_av_address", {22'b0, bus.address}, 0);
        check("mid_rst_av_writedata", {24'b0, bus.writedata}, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_state", {29'b0, dbg_state}, 0);
        check("post_rst_reads_left", exp_rd_q.size(), 0);
        check("post_rst_writes_left", exp_wr_q.size(), 0);
        check("post_rst_ram380", {24'b0, mem[10'h380]}, 32'hA0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
        $fatal(1);
    end

endmodule
